// File: rtl/key_pulse_gen_if.sv
// Pushbutton-to-pulse bus: raw key and repeat enable in, debounced strobes out.
// The master side drives the key; the slave side is the pulse generator.
interface key_pulse_gen_if;
  logic KeyN;
  logic Enable;
  logic Pulse;
  logic Level;
  logic Repeating;

  modport master (output KeyN, output Enable,
                  input  Pulse, input Level, input Repeating);
  modport slave  (input  KeyN, input Enable,
                  output Pulse, output Level, output Repeating);
endinterface

// File: rtl/key_pulse_gen.sv
// Debounces one active-low pushbutton into a single-cycle count-enable strobe,
// with optional hold-to-auto-repeat, on the system clock.
module key_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic           Clk,
  input  logic           Resetn,
  key_pulse_gen_if.slave kp
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       sync_q;
  logic             key_s;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;
  logic             rep_q,   rep_d;

  // Two-flop synchronizer; resets to "released" so a held key re-debounces.
  always_ff @(posedge Clk) begin
    if (!Resetn) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], kp.KeyN};
  end

  assign key_s = ~sync_q[1];

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_q <= IDLE;
      timer_q <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      rep_q   <= rep_d;
    end
  end

  // Release always wins over a pending pulse; a dropped Enable in REPEAT
  // wins over a repeat strobe.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (key_s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d = HELD;
          timer_d = '0;
          pulse_d = 1'b1;
        end
      end
      HELD: begin
        if (!key_s) begin
          state_d = RELEASE_WAIT;
          timer_d = '0;
        end else if (!kp.Enable) begin
          timer_d = '0;
        end else if (timer_q == HOLD_LAST) begin
          state_d = REPEAT;
          timer_d = '0;
          pulse_d = 1'b1;
        end
      end
      REPEAT: begin
        if (!key_s) begin
          state_d = RELEASE_WAIT;
          timer_d = '0;
        end else if (!kp.Enable) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == REP_LAST) begin
          timer_d = '0;
          pulse_d = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == RELEASE_WAIT);
    rep_d   = (state_d == REPEAT);
  end

  assign kp.Pulse     = pulse_q;
  assign kp.Level     = level_q;
  assign kp.Repeating = rep_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed scenarios plus randomized key traffic, checked each cycle against a
// run-length model of the debouncer and hold/repeat timing.
module tb_key_pulse_gen;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic Clk = 1'b0;
  logic Resetn;
  key_pulse_gen_if kp_if ();

  key_pulse_gen #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R),
    .CNT_W          (8)
  ) dut (
    .Clk   (Clk),
    .Resetn(Resetn),
    .kp    (kp_if.slave)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: debounced level flips once the synced key has disagreed
  // with it for D+1 consecutive samples; g counts uninterrupted "held and
  // enabled" samples, repeats fall at g = H, H+R, H+2R, ...
  int m_s1, m_s2, m_lvl, m_run, m_g, m_prev0;
  int e_pulse, e_level, e_rep;

  int edge_n;
  int plog[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int kn, input int en, input int rn);
    int ks;
    if (rn == 0) begin
      m_s1 = 1; m_s2 = 1; m_lvl = 0; m_run = 0; m_g = 0; m_prev0 = 0;
      e_pulse = 0; e_level = 0; e_rep = 0;
      return;
    end
    ks = (m_s2 == 0) ? 1 : 0;
    m_s2 = m_s1;
    m_s1 = kn;
    e_pulse = 0;
    m_run = (ks != m_lvl) ? m_run + 1 : 0;
    if (m_lvl == 0) begin
      if (m_run == D + 1) begin
        m_lvl = 1; m_run = 0; m_g = 0; e_pulse = 1;
      end
    end else begin
      if (m_run == D + 1) begin
        m_lvl = 0; m_run = 0; m_g = 0;
      end else if (ks == 0 || m_prev0 == 1 || en == 0) begin
        m_g = 0;
      end else begin
        m_g++;
        if (m_g >= H && (m_g - H) % R == 0) e_pulse = 1;
      end
    end
    m_prev0 = (ks == 0) ? 1 : 0;
    e_level = m_lvl;
    e_rep   = (m_lvl == 1 && m_g >= H) ? 1 : 0;
  endtask

  task automatic cycle(input int kn, input int en, input int rn);
    kp_if.KeyN   = kn[0];
    kp_if.Enable = en[0];
    Resetn       = rn[0];
    @(posedge Clk);
    #1;
    edge_n++;
    model_step(kn, en, rn);
    if (kp_if.Pulse === 1'b1) plog.push_back(edge_n);
    check("pulse", int'(kp_if.Pulse), e_pulse);
    check("level", int'(kp_if.Level), e_level);
    check("repeating", int'(kp_if.Repeating), e_rep);
  endtask

  task automatic run(input int n, input int kn, input int en, input int rn);
    for (int i = 0; i < n; i++) cycle(kn, en, rn);
  endtask

  task automatic start_scn();
    plog.delete();
    edge_n = -1;
  endtask

  task automatic check_log(input string tag, input int n, input int e [6]);
    check({tag, "_count"}, plog.size(), n);
    for (int i = 0; i < n; i++) check({tag, "_edge"}, (i < plog.size()) ? plog[i] : -1, e[i]);
  endtask

  int kval, en_r, len;

  initial begin
    edge_n = 0;
    kp_if.KeyN = 1'b1;
    kp_if.Enable = 1'b1;
    Resetn = 1'b0;

    run(3, 1, 1, 0);
    run(5, 1, 1, 1);

    // Clean press: one pulse at edge 6, level falls at edge 21
    start_scn();
    run(15, 0, 1, 1);
    run(12, 1, 1, 1);
    check_log("clean", 1, '{6, 0, 0, 0, 0, 0});

    // Bounce: low 3, high 1, then steady low
    start_scn();
    run(3, 0, 1, 1);
    run(1, 1, 1, 1);
    run(12, 0, 1, 1);
    run(12, 1, 1, 1);
    check_log("bounce", 1, '{10, 0, 0, 0, 0, 0});

    // Auto-repeat with key held for edges 0..59
    start_scn();
    run(60, 0, 1, 1);
    run(12, 1, 1, 1);
    check_log("repeat", 6, '{6, 26, 34, 42, 50, 58});

    // Same hold with repeat disabled
    start_scn();
    run(60, 0, 0, 1);
    run(12, 1, 0, 1);
    check_log("norepeat", 1, '{6, 0, 0, 0, 0, 0});

    // One-cycle low glitch while release is debouncing
    start_scn();
    run(10, 0, 1, 1);
    run(3, 1, 1, 1);
    run(1, 0, 1, 1);
    run(12, 1, 1, 1);
    check_log("relglitch", 1, '{6, 0, 0, 0, 0, 0});

    // Reset for two edges at edge 30 with the key still held
    start_scn();
    run(30, 0, 1, 1);
    run(2, 0, 1, 0);
    run(20, 0, 1, 1);
    run(12, 1, 1, 1);
    check_log("rstrep", 3, '{6, 26, 38, 0, 0, 0});

    // Randomized key runs, enable toggles and occasional resets
    kval = 0;
    en_r = 1;
    for (int b = 0; b < 60; b++) begin
      len = $urandom_range(1, 30);
      if ($urandom_range(0, 5) == 0) en_r = 1 - en_r;
      if ($urandom_range(0, 20) == 0) run($urandom_range(1, 2), kval, en_r, 0);
      run(len, kval, en_r, 1);
      kval = 1 - kval;
    end
    run(12, 1, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_pulse_gen.md
# key_pulse_gen

Debounces one active-low DE2 pushbutton and produces a single-cycle count-enable pulse per confirmed press, with optional hold-to-auto-repeat. Sits directly upstream of the 16-bit T-flip-flop counter: `Pulse` drives the counter's enable, and the counter then runs on the 50 MHz system clock instead of being clocked by a raw key. Also exports the debounced key level for LEDs or other consumers.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a press or a release (10 ms at 50 MHz); must be ≥ 2.
- `HOLD_CYCLES`, default 25000000: cycles in HELD before auto-repeat starts.
- `REPEAT_CYCLES`, default 5000000: period between auto-repeat pulses; must be ≥ 2.
- `CNT_W`, default 25: timer width; must hold max(all three parameters) − 1.
- `Clk`  in  1  system clock (CLOCK_50); single clock domain.
- `Resetn`  in  1  synchronous, active-low reset.
- `KeyN`  in  1  raw pushbutton, active-low, asynchronous and bouncy.
- `Enable`  in  1  auto-repeat enable (level).
- `Pulse`  out  1  one-cycle press/repeat strobe, registered.
- `Level`  out  1  debounced pressed state, registered.
- `Repeating`  out  1  high while in REPEAT, registered.

## Operation
- Synchronizer: two flops on `KeyN`, both reset to 1 (released). `key_s` = inverted second-stage output (1 = pressed).
- One shared timer, `CNT_W` bits, cleared on every state transition.
- **IDLE**: `Level` = 0. If `key_s` = 1, go to PRESS_WAIT.
- **PRESS_WAIT**: `Level` = 0.
  - `key_s` = 0: return to IDLE (bounce rejected, no pulse).
  - Otherwise the timer increments. When timer = DEBOUNCE_CYCLES−1 and `key_s` = 1, go to HELD and assert `Pulse`.
- **HELD**: `Level` = 1.
  - `key_s` = 0: go to RELEASE_WAIT.
  - Otherwise the timer increments only while `Enable` = 1 and is held at 0 while `Enable` = 0.
  - When timer = HOLD_CYCLES−1, go to REPEAT and assert `Pulse`.
- **REPEAT**: `Level` = 1, `Repeating` = 1.
  - `key_s` = 0: go to RELEASE_WAIT.
  - `Enable` = 0: go to HELD (timer cleared, no pulse).
  - Otherwise the timer counts; at timer = REPEAT_CYCLES−1, assert `Pulse` and clear the timer, staying in REPEAT.
- **RELEASE_WAIT**: `Level` = 1.
  - `key_s` = 1: go to HELD (glitch; timer cleared, no pulse).
  - Otherwise the timer increments; at DEBOUNCE_CYCLES−1 with `key_s` = 0, go to IDLE.
- Simultaneous events: release (`key_s` = 0) has priority over any pulse in HELD/REPEAT, so no pulse is emitted on the release cycle. In REPEAT, `Enable` = 0 has priority over a repeat pulse.
- `Pulse` is never high on two consecutive cycles.
- Exactly one non-repeat pulse per accepted press.

## Timing
- Reset: when `Resetn` = 0 at a rising edge, the next state is IDLE, timer = 0, sync flops = 1, and `Pulse`, `Level`, `Repeating` = 0.
- Reset mid-operation aborts the current state with no pulse.
- A key still held after reset release is treated as a new press and yields one pulse after full debounce.
- Press latency: edge 0 is the first edge sampling `KeyN` = 0, with the key stable thereafter.
  - PRESS_WAIT is entered at edge 2.
  - HELD is entered, and `Pulse` goes high, at edge DEBOUNCE_CYCLES+2.
  - `Pulse` falls at the following edge.
  - `Level` rises together with that pulse.
- First repeat pulse comes HOLD_CYCLES edges after HELD entry, provided `Enable` stays 1. Subsequent repeat pulses are every REPEAT_CYCLES edges.
- Release: measured from the first edge sampling `KeyN` = 1, `Level` falls at edge DEBOUNCE_CYCLES+2 (2 for the synchronizer, then the debounce count).

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, `Enable` = 1 unless stated, with edge 0 = first edge sampling `KeyN` = 0.
- **Clean press**: `KeyN` low for 15 cycles, then high. Required: exactly one `Pulse` at edge 6; `Level` = 1 from edge 6 and 0 from edge 21; `Repeating` stays 0.
- **Bounce rejection**: `KeyN` low 3 cycles, high 1, then low steady. Required: no pulse before 4 stable cycles, exactly one `Pulse` (at edge 10).
- **Auto-repeat**: `KeyN` low for edges 0–59. Required: `Pulse` at edges 6, 26, 34, 42, 50, 58 and no others; `Repeating` high from edge 26 until the RELEASE_WAIT entry at edge 62.
- **Repeat disabled**: same as auto-repeat with `Enable` = 0. Required: single `Pulse` at edge 6 and `Repeating` = 0 throughout.
- **Release glitch**: after a clean press and release, `KeyN` low for 1 cycle during RELEASE_WAIT. Required: no extra `Pulse`; `Level` stays 1 until a full 4-cycle stable release completes.
- **Reset mid-repeat**: `Resetn` low for 2 edges at edge 30 with the key held. Required: all outputs 0 at the next edge; a new `Pulse` 6 edges after the first edge with `Resetn` = 1, and the counter increments exactly once for it.
